// File: rtl/shared_mul_gf4_checker.sv
// Receive-side checker for a shared GF(2^4) multiplier: recombines the output shares,
// compares them with an unshared reference product and keeps sweep statistics.
module shared_mul_gf4_checker #(
  parameter int SHARES      = 2,
  parameter int LATENCY     = 1,
  parameter int NUM_VECTORS = 256,
  parameter int CNT_W       = 16
) (
  input  logic                  ClkxCI,
  input  logic                  RstxRI,
  input  logic                  StartxSI,
  input  logic                  InValidxSI,
  input  logic [3:0]            XxDI,
  input  logic [3:0]            YxDI,
  input  logic [4*SHARES-1:0]   _QxDI,
  output logic                  BusyxSO,
  output logic                  DonexSO,
  output logic                  PassxSO,
  output logic [CNT_W-1:0]      VecCntxDO,
  output logic [CNT_W-1:0]      ErrCntxDO,
  output logic [11:0]           FirstErrxDO
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  localparam logic [CNT_W-1:0] LastVec = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  // Normal basis (W, W^2) of GF(2^2); the element 1 is 2'b11.
  function automatic logic [1:0] gf2Mul(input logic [1:0] a, input logic [1:0] b);
    logic t;
    t = (a[1] ^ a[0]) & (b[1] ^ b[0]);
    return {(a[1] & b[1]) ^ t, (a[0] & b[0]) ^ t};
  endfunction

  function automatic logic [1:0] gf2ScaleN(input logic [1:0] a);
    return {a[1] ^ a[0], a[1]};
  endfunction

  // Tower multiply over GF(2^2) with N = W^2, so 4'hF is the multiplicative identity.
  function automatic logic [3:0] gf4Mul(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] e;
    e = gf2ScaleN(gf2Mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]));
    return {gf2Mul(a[3:2], b[3:2]) ^ e, gf2Mul(a[1:0], b[1:0]) ^ e};
  endfunction

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_vecCnt;
  logic [CNT_W-1:0] r_errCnt;
  logic [11:0]      r_firstErr;
  logic [8:0]       w_dlyOut;
  logic             w_dValid;
  logic [3:0]       w_dX;
  logic [3:0]       w_dY;
  logic [3:0]       w_qRecomb;
  logic             w_count;
  logic             w_mismatch;

  // The delay line runs in every state, so vectors in flight at Start are still counted.
  if (LATENCY == 0) begin : gNoDly
    assign w_dlyOut = {InValidxSI, XxDI, YxDI};
  end else begin : gDly
    logic [8:0] r_dly [LATENCY];
    always_ff @(posedge ClkxCI) begin
      if (RstxRI) begin
        for (int i = 0; i < LATENCY; i++) r_dly[i] <= '0;
      end else begin
        r_dly[0] <= {InValidxSI, XxDI, YxDI};
        for (int i = 1; i < LATENCY; i++) r_dly[i] <= r_dly[i-1];
      end
    end
    assign w_dlyOut = r_dly[LATENCY-1];
  end

  assign w_dValid = w_dlyOut[8];
  assign w_dX     = w_dlyOut[7:4];
  assign w_dY     = w_dlyOut[3:0];

  always_comb begin
    w_qRecomb = '0;
    for (int i = 0; i < SHARES; i++) w_qRecomb = w_qRecomb ^ _QxDI[4*i +: 4];
  end

  assign w_count    = (r_state == StRun) && w_dValid && !StartxSI;
  assign w_mismatch = (w_qRecomb != gf4Mul(w_dX, w_dY));

  always_ff @(posedge ClkxCI) begin
    if (RstxRI) r_state <= StIdle;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (StartxSI) w_nextState = StRun;
    else if (w_count && (r_vecCnt == LastVec)) w_nextState = StDone;
  end

  always_comb begin
    BusyxSO = 1'b0;
    DonexSO = 1'b0;
    unique case (r_state)
      StRun:   BusyxSO = 1'b1;
      StDone:  DonexSO = 1'b1;
      default: ;
    endcase
  end

  // The final vector's error update lands on the same edge that enters DONE.
  always_ff @(posedge ClkxCI) begin
    if (RstxRI || StartxSI) begin
      r_vecCnt   <= '0;
      r_errCnt   <= '0;
      r_firstErr <= '0;
    end else if (w_count) begin
      if (r_vecCnt != CntMax) r_vecCnt <= r_vecCnt + CNT_W'(1);
      if (w_mismatch) begin
        if (r_errCnt != CntMax) r_errCnt <= r_errCnt + CNT_W'(1);
        if (r_errCnt == '0) r_firstErr <= {w_dX, w_dY, w_qRecomb};
      end
    end
  end

  assign PassxSO     = DonexSO && (r_errCnt == '0);
  assign VecCntxDO   = r_vecCnt;
  assign ErrCntxDO   = r_errCnt;
  assign FirstErrxDO = r_firstErr;

endmodule

// File: tb/tb_shared_mul_gf4_checker.sv
// Randomised bench for shared_mul_gf4_checker: emulates a shared multiplier feeding it
// and predicts counts, first error and pass/fail from a polynomial-basis field model.
module tb_shared_mul_gf4_checker;

  localparam int SHARES      = 2;
  localparam int LATENCY     = 1;
  localparam int NUM_VECTORS = 256;
  localparam int CNT_W       = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                inValid;
  logic [3:0]          xIn;
  logic [3:0]          yIn;
  logic [4*SHARES-1:0] qShares;
  logic                busy;
  logic                done;
  logic                pass;
  logic [CNT_W-1:0]    vecCnt;
  logic [CNT_W-1:0]    errCnt;
  logic [11:0]         firstErr;

  int checkCount = 0;
  int errorCount = 0;
  logic [4*SHARES-1:0] shareQueue[$];

  always #5 clk = ~clk;

  shared_mul_gf4_checker #(
    .SHARES(SHARES), .LATENCY(LATENCY), .NUM_VECTORS(NUM_VECTORS), .CNT_W(CNT_W)
  ) dut (
    .ClkxCI(clk), .RstxRI(rst), .StartxSI(start), .InValidxSI(inValid),
    .XxDI(xIn), .YxDI(yIn), ._QxDI(qShares),
    .BusyxSO(busy), .DonexSO(done), .PassxSO(pass),
    .VecCntxDO(vecCnt), .ErrCntxDO(errCnt), .FirstErrxDO(firstErr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // GF(4) via discrete logs: 2'b11 = 1, 2'b10 = W, 2'b01 = W^2.
  function automatic int gf2Log(input logic [1:0] a);
    return (a == 2'b11) ? 0 : (a == 2'b10) ? 1 : 2;
  endfunction

  function automatic logic [1:0] gf2Ref(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'b00 || b == 2'b00) return 2'b00;
    case ((gf2Log(a) + gf2Log(b)) % 3)
      0:       return 2'b11;
      1:       return 2'b10;
      default: return 2'b01;
    endcase
  endfunction

  // GF(16) = GF(4)[Y]/(Y^2+Y+N), N = W^2; nibble {h,l} means h*Y^4 + l*Y with Y^4 = Y+1.
  function automatic logic [3:0] refMul(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] p1, p0, q1, q0, c1, c0;
    p1 = a[3:2] ^ a[1:0];
    p0 = a[3:2];
    q1 = b[3:2] ^ b[1:0];
    q0 = b[3:2];
    c1 = gf2Ref(p1, q1) ^ gf2Ref(p1, q0) ^ gf2Ref(p0, q1);
    c0 = gf2Ref(p0, q0) ^ gf2Ref(2'b01, gf2Ref(p1, q1));
    return {c0, c1 ^ c0};
  endfunction

  // One cycle of stimulus; the emulated multiplier returns qv as shares LATENCY cycles later.
  task automatic applyStimulus(input logic st, input logic v, input logic [3:0] xv,
                               input logic [3:0] yv, input logic [3:0] qv, input logic [3:0] mask);
    logic [4*SHARES-1:0] sh;
    @(negedge clk);
    start   = st;
    inValid = v;
    xIn     = xv;
    yIn     = yv;
    sh      = '0;
    sh[3:0] = qv ^ mask;
    sh[7:4] = mask;
    shareQueue.push_back(sh);
    if (shareQueue.size() > LATENCY) qShares = shareQueue.pop_front();
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic startSweep();
    repeat (LATENCY + 1) idleCycle();
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    idleCycle();
    checkOutput("startVecCnt", 32'(vecCnt), 32'd0);
    checkOutput("startBusy", 32'(busy), 32'd1);
    checkOutput("startDone", 32'(done), 32'd0);
  endtask

  task automatic runSweep(input string name, input bit gaps, input bit masked,
                          input bit fault, input int abortAt);
    int expErr = 0;
    logic [11:0] expFirst = '0;
    logic [7:0] idx8;
    logic [3:0] xv, yv, qv, mask;
    startSweep();
    for (int idx = 0; idx < NUM_VECTORS; idx++) begin
      idx8 = 8'(idx);
      xv   = idx8[7:4];
      yv   = idx8[3:0];
      if (gaps && (idx % 3 == 2)) idleCycle();
      qv = refMul(xv, yv);
      if (fault && xv == 4'h3 && yv == 4'h5) begin
        qv = qv ^ 4'h1;
        if (expErr == 0) expFirst = {xv, yv, qv};
        expErr++;
      end
      mask = masked ? 4'($urandom_range(1, 15)) : 4'h0;
      applyStimulus(1'b0, 1'b1, xv, yv, qv, mask);
      if (idx == abortAt) begin
        rst = 1'b1;
        idleCycle();
        rst = 1'b0;
        checkOutput({name, "_rstBusy"}, 32'(busy), 32'd0);
        checkOutput({name, "_rstDone"}, 32'(done), 32'd0);
        checkOutput({name, "_rstPass"}, 32'(pass), 32'd0);
        checkOutput({name, "_rstVec"}, 32'(vecCnt), 32'd0);
        checkOutput({name, "_rstErr"}, 32'(errCnt), 32'd0);
        checkOutput({name, "_rstFirst"}, 32'(firstErr), 32'd0);
        return;
      end
    end
    repeat (LATENCY) idleCycle();
    checkOutput({name, "_preDone"}, 32'(done), 32'd0);
    checkOutput({name, "_preVec"}, 32'(vecCnt), 32'(NUM_VECTORS - 1));
    idleCycle();
    checkOutput({name, "_done"}, 32'(done), 32'd1);
    checkOutput({name, "_busy"}, 32'(busy), 32'd0);
    checkOutput({name, "_vec"}, 32'(vecCnt), 32'(NUM_VECTORS));
    checkOutput({name, "_err"}, 32'(errCnt), 32'(expErr));
    checkOutput({name, "_first"}, 32'(firstErr), 32'(expFirst));
    checkOutput({name, "_pass"}, 32'(pass), 32'(expErr == 0));
    // Vectors after DONE, even wrong ones, must leave the results frozen.
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b0, 1'b1, 4'h3, 4'h5, refMul(4'h3, 4'h5) ^ 4'h6, 4'h0);
    repeat (LATENCY + 1) idleCycle();
    checkOutput({name, "_frozenVec"}, 32'(vecCnt), 32'(NUM_VECTORS));
    checkOutput({name, "_frozenErr"}, 32'(errCnt), 32'(expErr));
    checkOutput({name, "_frozenDone"}, 32'(done), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; inValid = 1'b0; xIn = '0; yIn = '0; qShares = '0;
    repeat (3) idleCycle();
    rst = 1'b0;
    idleCycle();
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_pass", 32'(pass), 32'd0);
    checkOutput("reset_vec", 32'(vecCnt), 32'd0);
    checkOutput("reset_err", 32'(errCnt), 32'd0);
    checkOutput("reset_first", 32'(firstErr), 32'd0);

    // Wrong products while IDLE must not be counted.
    for (int k = 0; k < 4; k++)
      applyStimulus(1'b0, 1'b1, 4'h7, 4'h9, refMul(4'h7, 4'h9) ^ 4'h8, 4'h0);
    repeat (LATENCY + 1) idleCycle();
    checkOutput("idle_vec", 32'(vecCnt), 32'd0);
    checkOutput("idle_err", 32'(errCnt), 32'd0);

    runSweep("plain", 1'b0, 1'b0, 1'b0, -1);

    // Identity and zero rules are driven from first principles, not from refMul.
    startSweep();
    for (int j = 0; j < 16; j++) begin
      applyStimulus(1'b0, 1'b1, 4'hF, 4'(j), 4'(j), 4'($urandom));
      applyStimulus(1'b0, 1'b1, 4'h0, 4'(j), 4'h0, 4'($urandom));
    end
    repeat (LATENCY + 1) idleCycle();
    checkOutput("ident_vec", 32'(vecCnt), 32'd32);
    checkOutput("ident_err", 32'(errCnt), 32'd0);
    checkOutput("ident_busy", 32'(busy), 32'd1);

    runSweep("masked", 1'b0, 1'b1, 1'b0, -1);
    runSweep("fault", 1'b0, 1'b1, 1'b1, -1);
    runSweep("abort", 1'b0, 1'b1, 1'b0, 100);
    runSweep("afterAbort", 1'b0, 1'b1, 1'b0, -1);
    runSweep("gaps", 1'b1, 1'b1, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
